// File: rtl/dmux16_stream.sv
`default_nettype none
// ============================================================================
// Module      : dmux16_stream
// Description : 1-to-2 stream demultiplexer for 16-bit words. Each accepted
//               input word is steered by in_sel into a one-word register
//               slice on channel 0 or 1, each with a valid/ready handshake.
//               Per-channel accept counters give transfer visibility.
// Revision    : 1.0 - initial release
// ============================================================================
module dmux16_stream #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [15:0]      out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } ch_state_t;

  ch_state_t        r_st0, r_st1;
  ch_state_t        w_nst0, w_nst1;
  logic [15:0]      r_data0, r_data1;
  logic [CNT_W-1:0] r_cnt0, r_cnt1;
  logic             w_ready;
  logic             w_acc0, w_acc1;

  // The selected slot can take a word when it is empty or is being drained
  // this cycle; the other channel plays no part in the decision.
  always_comb begin
    w_ready = 1'b1;
    if (in_sel) begin
      w_ready = (r_st1 == S_EMPTY) | out1_ready;
    end else begin
      w_ready = (r_st0 == S_EMPTY) | out0_ready;
    end
  end

  assign w_acc0 = in_valid & w_ready & ~in_sel;
  assign w_acc1 = in_valid & w_ready &  in_sel;

  // Next-state for both channel slots: accept fills, drain without refill empties.
  always_comb begin
    w_nst0 = r_st0;
    w_nst1 = r_st1;
    if (w_acc0) begin
      w_nst0 = S_FULL;
    end else if (r_st0 == S_FULL && out0_ready) begin
      w_nst0 = S_EMPTY;
    end
    if (w_acc1) begin
      w_nst1 = S_FULL;
    end else if (r_st1 == S_FULL && out1_ready) begin
      w_nst1 = S_EMPTY;
    end
  end

  // Channel state registers; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st0 <= S_EMPTY;
      r_st1 <= S_EMPTY;
    end else begin
      r_st0 <= w_nst0;
      r_st1 <= w_nst1;
    end
  end

  // Data slots load only on an accept to their own channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data0 <= 16'h0000;
      r_data1 <= 16'h0000;
    end else begin
      if (w_acc0) r_data0 <= in_data;
      if (w_acc1) r_data1 <= in_data;
    end
  end

  // Accept counters wrap naturally; a clear overrides a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (clr_cnt) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_acc0) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_acc1) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign in_ready   = w_ready;
  assign out0_data  = r_data0;
  assign out1_data  = r_data1;
  assign out0_valid = (r_st0 == S_FULL);
  assign out1_valid = (r_st1 == S_FULL);
  assign cnt0       = r_cnt0;
  assign cnt1       = r_cnt1;

endmodule
`default_nettype wire
